// File: rtl/terminal_fifo_pkg.sv
// Shared constants for the terminal byte buffer: data width, flag-word bit
// positions as seen by Forth through the io_addr[13] status word, and the
// sticky-flag update rule.
package terminal_fifo_pkg;

  localparam int TERM_DW = 8;

  // Flag-word bit positions
  localparam int FLAG_TX_READY    = 0;
  localparam int FLAG_RX_VALID    = 1;
  localparam int FLAG_RANDOM      = 2;
  localparam int FLAG_TX_OVERFLOW = 3;
  localparam int FLAG_RX_OVERFLOW = 4;

  // Sticky flag: a set in the same cycle as a clear wins.
  function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
    return set | (cur & ~clr);
  endfunction

endpackage

// File: rtl/terminal_fifo_byte_fifo.sv
// Circular byte FIFO with show-ahead head. Storage is a plain array read
// combinationally from the registered read pointer, so it maps to LUT RAM or
// flops rather than a read-latency block RAM. The array is never cleared;
// an empty FIFO presents 8'h00 at its head instead.
module byte_fifo
  import terminal_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [TERM_DW-1:0] push_data,
  input  logic               pop,
  output logic [TERM_DW-1:0] head,
  output logic [AW:0]        count,
  output logic               full,
  output logic               empty
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [TERM_DW-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage write; deliberately not reset so buffered bytes are simply abandoned
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/terminal_fifo.sv
// Terminal byte buffer between the J1 IO port and the usb_cdc app streams.
// TX: CPU pushes, USB IN handshake pops. RX: USB OUT handshake pushes, CPU
// pops. This level only holds the handshake glue and the sticky overflow flags.
module terminal_fifo
  import terminal_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_tx_wr,
  input  logic [TERM_DW-1:0] cpu_tx_data,
  input  logic               cpu_rx_rd,
  output logic [TERM_DW-1:0] cpu_rx_data,
  input  logic               cpu_flags_clr,
  output logic               tx_ready,
  output logic               rx_valid,
  output logic               tx_overflow,
  output logic               rx_overflow,
  output logic [AW:0]        tx_level,
  output logic [AW:0]        rx_level,
  output logic [TERM_DW-1:0] usb_in_data,
  output logic               usb_in_valid,
  input  logic               usb_in_ready,
  input  logic [TERM_DW-1:0] usb_out_data,
  input  logic               usb_out_valid,
  output logic               usb_out_ready
);

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_pop, rx_push;
  logic tx_over_set, rx_over_set;

  // Status comes only from registered counts, so usb_out_ready never depends
  // combinationally on usb_out_valid.
  assign tx_ready      = ~tx_full;
  assign usb_in_valid  = ~tx_empty;
  assign rx_valid      = ~rx_empty;
  assign usb_out_ready = ~rx_full;

  assign tx_pop  = usb_in_valid & usb_in_ready;
  assign rx_push = usb_out_valid & usb_out_ready;

  // A push into a full FIFO is only lost when no pop frees a slot that cycle.
  // RX push is gated by usb_out_ready, so its flag only fires if that gating is bypassed.
  assign tx_over_set = cpu_tx_wr & tx_full & ~tx_pop;
  assign rx_over_set = rx_push & rx_full & ~(cpu_rx_rd & rx_valid);

  byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cpu_tx_wr),
    .push_data (cpu_tx_data),
    .pop       (tx_pop),
    .head      (usb_in_data),
    .count     (tx_level),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (usb_out_data),
    .pop       (cpu_rx_rd),
    .head      (cpu_rx_data),
    .count     (rx_level),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // Sticky overflow flags; set beats clear in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_overflow <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      tx_overflow <= sticky_next(tx_overflow, tx_over_set, cpu_flags_clr);
      rx_overflow <= sticky_next(rx_overflow, rx_over_set, cpu_flags_clr);
    end
  end

endmodule

// File: tb/tb_terminal_fifo.sv
// Directed bench for terminal_fifo: reset state, TX ordering and backpressure,
// TX overflow and flag clear, full push+pop, empty push+pop, RX fill/drain
// and empty read, asynchronous reset mid-stream.
module tb_terminal_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_tx_wr;
  logic [7:0] cpu_tx_data;
  logic       cpu_rx_rd;
  logic [7:0] cpu_rx_data;
  logic       cpu_flags_clr;
  logic       tx_ready, rx_valid, tx_overflow, rx_overflow;
  logic [4:0] tx_level, rx_level;
  logic [7:0] usb_in_data;
  logic       usb_in_valid;
  logic       usb_in_ready;
  logic [7:0] usb_out_data;
  logic       usb_out_valid;
  logic       usb_out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  terminal_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_tx_wr     (cpu_tx_wr),
    .cpu_tx_data   (cpu_tx_data),
    .cpu_rx_rd     (cpu_rx_rd),
    .cpu_rx_data   (cpu_rx_data),
    .cpu_flags_clr (cpu_flags_clr),
    .tx_ready      (tx_ready),
    .rx_valid      (rx_valid),
    .tx_overflow   (tx_overflow),
    .rx_overflow   (rx_overflow),
    .tx_level      (tx_level),
    .rx_level      (rx_level),
    .usb_in_data   (usb_in_data),
    .usb_in_valid  (usb_in_valid),
    .usb_in_ready  (usb_in_ready),
    .usb_out_data  (usb_out_data),
    .usb_out_valid (usb_out_valid),
    .usb_out_ready (usb_out_ready)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    cpu_tx_wr = 0; cpu_tx_data = 0; cpu_rx_rd = 0; cpu_flags_clr = 0;
    usb_in_ready = 0; usb_out_data = 0; usb_out_valid = 0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // 1. Reset / idle state
    chk("rst_tx_ready", 16'(tx_ready), 16'h1);
    chk("rst_rx_valid", 16'(rx_valid), 16'h0);
    chk("rst_in_valid", 16'(usb_in_valid), 16'h0);
    chk("rst_out_ready", 16'(usb_out_ready), 16'h1);
    chk("rst_tx_level", 16'(tx_level), 16'h0);
    chk("rst_rx_level", 16'(rx_level), 16'h0);
    chk("rst_tx_ovf", 16'(tx_overflow), 16'h0);
    chk("rst_rx_ovf", 16'(rx_overflow), 16'h0);
    chk("rst_in_data", 16'(usb_in_data), 16'h0);
    chk("rst_rx_data", 16'(cpu_rx_data), 16'h0);

    // 2. Three bytes held by backpressure, then released on consecutive cycles
    cpu_tx_wr = 1;
    for (int i = 0; i < 3; i++) begin
      cpu_tx_data = 8'h41 + 8'(i);
      tick();
      $display("tx push %02h level=%0d", cpu_tx_data, tx_level);
    end
    cpu_tx_wr = 0;
    chk("t2_level", 16'(tx_level), 16'd3);
    chk("t2_head", 16'(usb_in_data), 16'h41);
    chk("t2_valid", 16'(usb_in_valid), 16'h1);
    usb_in_ready = 1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_out_valid", 16'(usb_in_valid), 16'h1);
      chk("t2_out_data", 16'(usb_in_data), 16'(8'h41 + 8'(i)));
      $display("tx pop %02h", usb_in_data);
      tick();
    end
    chk("t2_drained_valid", 16'(usb_in_valid), 16'h0);
    chk("t2_drained_level", 16'(tx_level), 16'd0);
    usb_in_ready = 0;

    // 3. 17 writes into a stalled TX: last byte dropped, flag sticky until cleared
    cpu_tx_wr = 1;
    for (int i = 0; i < 17; i++) begin
      cpu_tx_data = 8'(i);
      tick();
      $display("tx push %02h level=%0d ovf=%0b", cpu_tx_data, tx_level, tx_overflow);
      if (i == 15) chk("t3_no_ovf_at_16", 16'(tx_overflow), 16'h0);
    end
    cpu_tx_wr = 0;
    chk("t3_level", 16'(tx_level), 16'd16);
    chk("t3_tx_ready", 16'(tx_ready), 16'h0);
    chk("t3_ovf", 16'(tx_overflow), 16'h1);
    usb_in_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("t3_drain_data", 16'(usb_in_data), 16'(i));
      $display("tx pop %02h", usb_in_data);
      tick();
    end
    usb_in_ready = 0;
    chk("t3_drained_valid", 16'(usb_in_valid), 16'h0);
    chk("t3_ovf_sticky", 16'(tx_overflow), 16'h1);
    cpu_flags_clr = 1;
    tick();
    cpu_flags_clr = 0;
    chk("t3_ovf_cleared", 16'(tx_overflow), 16'h0);

    // 4. Full TX with simultaneous push and pop: both accepted, no overflow
    cpu_tx_wr = 1;
    for (int i = 0; i < 16; i++) begin
      cpu_tx_data = 8'h50 + 8'(i);
      tick();
    end
    chk("t4_full_level", 16'(tx_level), 16'd16);
    cpu_tx_data = 8'hAA;
    usb_in_ready = 1;
    chk("t4_pop_data", 16'(usb_in_data), 16'h50);
    tick();
    cpu_tx_wr = 0;
    usb_in_ready = 0;
    $display("tx push+pop while full level=%0d ovf=%0b", tx_level, tx_overflow);
    chk("t4_level_kept", 16'(tx_level), 16'd16);
    chk("t4_no_ovf", 16'(tx_overflow), 16'h0);
    usb_in_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("t4_drain_data", 16'(usb_in_data), (i == 15) ? 16'hAA : 16'(8'h51 + 8'(i)));
      $display("tx pop %02h", usb_in_data);
      tick();
    end
    chk("t4_drained_level", 16'(tx_level), 16'd0);

    // 4b. Push+pop into empty TX: no bypass, byte shows up next cycle
    cpu_tx_wr = 1;
    cpu_tx_data = 8'h77;
    chk("t4b_valid_before", 16'(usb_in_valid), 16'h0);
    tick();
    cpu_tx_wr = 0;
    usb_in_ready = 0;
    chk("t4b_level", 16'(tx_level), 16'd1);
    chk("t4b_head", 16'(usb_in_data), 16'h77);
    usb_in_ready = 1;
    tick();
    usb_in_ready = 0;
    chk("t4b_drained", 16'(tx_level), 16'd0);

    // 5. Host fills RX, CPU reads in order, then an extra read on empty
    usb_out_valid = 1;
    for (int i = 0; i < 16; i++) begin
      usb_out_data = 8'h30 + 8'(i);
      chk("t5_out_ready", 16'(usb_out_ready), 16'h1);
      tick();
      $display("rx push %02h level=%0d", usb_out_data, rx_level);
    end
    usb_out_valid = 0;
    chk("t5_not_ready", 16'(usb_out_ready), 16'h0);
    chk("t5_level", 16'(rx_level), 16'd16);
    chk("t5_rx_valid", 16'(rx_valid), 16'h1);
    cpu_rx_rd = 1;
    for (int i = 0; i < 16; i++) begin
      chk("t5_rd_data", 16'(cpu_rx_data), 16'(8'h30 + 8'(i)));
      $display("rx pop %02h", cpu_rx_data);
      tick();
    end
    chk("t5_empty_level", 16'(rx_level), 16'd0);
    chk("t5_empty_valid", 16'(rx_valid), 16'h0);
    tick();
    cpu_rx_rd = 0;
    chk("t5_17th_level", 16'(rx_level), 16'd0);
    chk("t5_17th_data", 16'(cpu_rx_data), 16'h00);
    chk("t5_rx_ovf", 16'(rx_overflow), 16'h0);
    chk("t5_ready_back", 16'(usb_out_ready), 16'h1);

    // 6. Asynchronous reset with 5 TX and 3 RX bytes queued
    cpu_tx_wr = 1;
    for (int i = 0; i < 5; i++) begin
      cpu_tx_data = 8'hC0 + 8'(i);
      usb_out_valid = (i < 3);
      usb_out_data = 8'hD0 + 8'(i);
      tick();
    end
    cpu_tx_wr = 0;
    usb_out_valid = 0;
    chk("t6_tx_queued", 16'(tx_level), 16'd5);
    chk("t6_rx_queued", 16'(rx_level), 16'd3);
    #2;
    reset = 1'b1;
    #1;
    $display("async reset tx_level=%0d rx_level=%0d", tx_level, rx_level);
    chk("t6_tx_level_async", 16'(tx_level), 16'd0);
    chk("t6_rx_level_async", 16'(rx_level), 16'd0);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("t6_in_valid", 16'(usb_in_valid), 16'h0);
    chk("t6_rx_valid", 16'(rx_valid), 16'h0);
    chk("t6_in_data", 16'(usb_in_data), 16'h00);
    chk("t6_rx_data", 16'(cpu_rx_data), 16'h00);
    chk("t6_tx_level", 16'(tx_level), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
